// File: rtl/scurve_inject_pulse_gen_if.sv
// Bus bundle between the S-curve test controller and the injection pulse generator.
// The controller side uses master and the generator uses slave.
interface scurve_inject_pulse_gen_if #(
  parameter int CNT_W  = 16,
  parameter int TIME_W = 16
);
  logic              Test_Start;
  logic [CNT_W-1:0]  Pulse_Number;
  logic [TIME_W-1:0] Pulse_High;
  logic [TIME_W-1:0] Pulse_Period;
  logic              CLK_EXT;
  logic [CNT_W-1:0]  Pulses_Sent;
  logic              Gen_Busy;
  logic              Gen_Done;

  modport master (
    output Test_Start, Pulse_Number, Pulse_High, Pulse_Period,
    input  CLK_EXT, Pulses_Sent, Gen_Busy, Gen_Done
  );

  modport slave (
    input  Test_Start, Pulse_Number, Pulse_High, Pulse_Period,
    output CLK_EXT, Pulses_Sent, Gen_Busy, Gen_Done
  );
endinterface

// File: rtl/scurve_inject_pulse_gen.sv
// Charge-injection pulse train generator for the S-curve trigger counters.
// Emits Pulse_Number pulses on CLK_EXT with programmable high time and period.
//
//  state | meaning
//  IDLE  | waiting for a Test_Start rising edge, run parameters latched on it
//  LOAD  | one-cycle setup; zero-pulse runs go straight to DONE
//  HIGH  | CLK_EXT high, timer counts the high phase
//  LOW   | CLK_EXT low, timer counts to the end of the period
//  DONE  | run complete, waits for Test_Start low as acknowledge
module scurve_inject_pulse_gen #(
  parameter int CNT_W  = 16,
  parameter int TIME_W = 16
) (
  input  logic                       Clk,
  input  logic                       reset_n,
  scurve_inject_pulse_gen_if.slave   gen_if
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Timer and phase lengths carry one extra bit so the period can reach
  // H+1 even when H is all ones.
  localparam logic [TIME_W:0]  T_ONE   = (TIME_W+1)'(1);
  localparam logic [TIME_W:0]  T_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic              start_d;
  logic              start_rise;
  logic [CNT_W-1:0]  num_q;
  logic [TIME_W:0]   high_q;
  logic [TIME_W:0]   period_q;
  logic [TIME_W:0]   timer_q;
  logic [CNT_W-1:0]  sent_q;
  logic              clk_ext_q;
  logic [TIME_W:0]   high_in;
  logic [TIME_W:0]   period_raw;
  logic [TIME_W:0]   period_in;
  logic              enter_high;
  logic              in_pulse;
  logic              stay_pulse;

  assign start_rise = gen_if.Test_Start & ~start_d;

  // Effective run parameters: high time of 0 means 1, period at least high+1.
  always_comb begin
    high_in    = {1'b0, gen_if.Pulse_High};
    period_raw = {1'b0, gen_if.Pulse_Period};
    if (gen_if.Pulse_High == '0) begin
      high_in = T_ONE;
    end
    if (period_raw > high_in) begin
      period_in = period_raw;
    end else begin
      period_in = high_in + T_ONE;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping Test_Start aborts any active phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!gen_if.Test_Start) begin
          state_d = ST_IDLE;
        end else if (num_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (!gen_if.Test_Start) begin
          state_d = ST_IDLE;
        end else if (timer_q == high_q) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (!gen_if.Test_Start) begin
          state_d = ST_IDLE;
        end else if (timer_q == period_q) begin
          if (sent_q == num_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HIGH;
          end
        end
      end
      ST_DONE: begin
        if (!gen_if.Test_Start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_pulse   = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign enter_high = (state_d == ST_HIGH) && (state_q != ST_HIGH);
  assign stay_pulse = in_pulse && ((state_d == ST_HIGH) || (state_d == ST_LOW));

  // Start edge detector.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      start_d <= 1'b0;
    end else begin
      start_d <= gen_if.Test_Start;
    end
  end

  // Run parameters are captured only on the start edge in IDLE.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      num_q    <= '0;
      high_q   <= T_ONE;
      period_q <= T_ONE + T_ONE;
    end else if ((state_q == ST_IDLE) && start_rise) begin
      num_q    <= gen_if.Pulse_Number;
      high_q   <= high_in;
      period_q <= period_in;
    end
  end

  // Phase timer: restarts at 1 on every rising edge of CLK_EXT and runs
  // through the high and low phases of one period.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= T_ZERO;
    end else if (enter_high) begin
      timer_q <= T_ONE;
    end else if (stay_pulse) begin
      timer_q <= timer_q + T_ONE;
    end
  end

  // Pulse counter: cleared at start, bumped on each emitted rising edge,
  // held on abort and in DONE so the count stays readable.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_q <= '0;
    end else if ((state_q == ST_IDLE) && start_rise) begin
      sent_q <= '0;
    end else if (enter_high) begin
      sent_q <= sent_q + CNT_ONE;
    end
  end

  // CLK_EXT is registered and high exactly while the next state is HIGH.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_ext_q <= 1'b0;
    end else begin
      clk_ext_q <= (state_d == ST_HIGH);
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    gen_if.CLK_EXT     = clk_ext_q;
    gen_if.Pulses_Sent = sent_q;
    gen_if.Gen_Busy    = (state_q == ST_LOAD) || (state_q == ST_HIGH) || (state_q == ST_LOW);
    gen_if.Gen_Done    = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_scurve_inject_pulse_gen.sv
// Directed bench for the S-curve injection pulse generator.
module tb_scurve_inject_pulse_gen;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rise_cnt = 0;

  scurve_inject_pulse_gen_if #(.CNT_W(16), .TIME_W(16)) gen_if ();

  scurve_inject_pulse_gen #(.CNT_W(16), .TIME_W(16)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .gen_if  (gen_if)
  );

  always #5 Clk = ~Clk;

  always @(posedge gen_if.CLK_EXT) rise_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts a run and checks the whole waveform cycle by cycle from the first
  // rising edge of CLK_EXT up to DONE. Test_Start is left high.
  task automatic run_wave(input string tag, input int n, input int h_raw, input int p_raw,
                          input int h_eff, input int p_eff, input bit change_mid);
    int werr;
    int rise0;
    werr = 0;
    gen_if.Pulse_Number = 16'(n);
    gen_if.Pulse_High   = 16'(h_raw);
    gen_if.Pulse_Period = 16'(p_raw);
    gen_if.Test_Start   = 1'b1;
    rise0 = rise_cnt;
    tick();
    chk({tag, "_load_busy"}, int'(gen_if.Gen_Busy), 1);
    chk({tag, "_load_sent"}, int'(gen_if.Pulses_Sent), 0);
    tick();
    for (int k = 0; k < n * p_eff; k++) begin
      if (k > 0) tick();
      if (gen_if.CLK_EXT !== ((k % p_eff) < h_eff)) werr++;
      if (int'(gen_if.Pulses_Sent) != (k / p_eff) + 1) werr++;
      if (gen_if.Gen_Done !== 1'b0 || gen_if.Gen_Busy !== 1'b1) werr++;
      if (change_mid && k == 5) begin
        gen_if.Pulse_Number = 16'd7;
        gen_if.Pulse_High   = 16'd1;
        gen_if.Pulse_Period = 16'd3;
      end
    end
    chk({tag, "_wave"}, werr, 0);
    tick();
    chk({tag, "_done"}, int'(gen_if.Gen_Done), 1);
    chk({tag, "_busy"}, int'(gen_if.Gen_Busy), 0);
    chk({tag, "_clk"}, int'(gen_if.CLK_EXT), 0);
    chk({tag, "_sent"}, int'(gen_if.Pulses_Sent), n);
    chk({tag, "_rises"}, rise_cnt - rise0, n);
  endtask

  task automatic ack();
    gen_if.Test_Start = 1'b0;
    tick();
  endtask

  initial begin
    int rise0;
    gen_if.Test_Start   = 1'b0;
    gen_if.Pulse_Number = '0;
    gen_if.Pulse_High   = '0;
    gen_if.Pulse_Period = '0;
    #12;
    chk("rst_clk", int'(gen_if.CLK_EXT), 0);
    chk("rst_sent", int'(gen_if.Pulses_Sent), 0);
    chk("rst_busy", int'(gen_if.Gen_Busy), 0);
    chk("rst_done", int'(gen_if.Gen_Done), 0);
    reset_n = 1'b1;
    tick();
    tick();

    // N=3 H=4 P=10 with inputs changed mid-run; done 30 cycles after first rise.
    run_wave("n3", 3, 4, 10, 4, 10, 1'b1);
    // Test_Start held high after DONE must not restart.
    rise0 = rise_cnt;
    repeat (6) tick();
    chk("hold_done", int'(gen_if.Gen_Done), 1);
    chk("hold_rises", rise_cnt - rise0, 0);
    chk("hold_sent", int'(gen_if.Pulses_Sent), 3);
    ack();
    chk("ack_done", int'(gen_if.Gen_Done), 0);
    chk("ack_sent", int'(gen_if.Pulses_Sent), 3);

    // N=0: done two edges after start, no pulse.
    gen_if.Pulse_Number = 16'd0;
    gen_if.Pulse_High   = 16'd4;
    gen_if.Pulse_Period = 16'd10;
    gen_if.Test_Start   = 1'b1;
    rise0 = rise_cnt;
    tick();
    chk("n0_busy", int'(gen_if.Gen_Busy), 1);
    chk("n0_sent", int'(gen_if.Pulses_Sent), 0);
    tick();
    chk("n0_done", int'(gen_if.Gen_Done), 1);
    chk("n0_clk", int'(gen_if.CLK_EXT), 0);
    chk("n0_rises", rise_cnt - rise0, 0);
    ack();

    // H=0,P=0 -> high 1, period 2.
    run_wave("h0p0", 2, 0, 0, 1, 2, 1'b0);
    ack();
    // H=5,P=5 -> period 6.
    run_wave("h5p5", 2, 5, 5, 5, 6, 1'b0);
    ack();

    // Abort after the 5th rising edge of a 100-pulse run.
    gen_if.Pulse_Number = 16'd100;
    gen_if.Pulse_High   = 16'd2;
    gen_if.Pulse_Period = 16'd8;
    gen_if.Test_Start   = 1'b1;
    tick();
    tick();
    repeat (32) tick();
    chk("abt_pre_clk", int'(gen_if.CLK_EXT), 1);
    chk("abt_pre_sent", int'(gen_if.Pulses_Sent), 5);
    gen_if.Test_Start = 1'b0;
    tick();
    chk("abt_clk", int'(gen_if.CLK_EXT), 0);
    chk("abt_busy", int'(gen_if.Gen_Busy), 0);
    chk("abt_done", int'(gen_if.Gen_Done), 0);
    chk("abt_sent", int'(gen_if.Pulses_Sent), 5);
    tick();
    chk("abt_idle_done", int'(gen_if.Gen_Done), 0);

    // Async reset during HIGH forces CLK_EXT low without a clock edge.
    gen_if.Pulse_Number = 16'd3;
    gen_if.Pulse_High   = 16'd4;
    gen_if.Pulse_Period = 16'd10;
    gen_if.Test_Start   = 1'b1;
    tick();
    tick();
    tick();
    chk("rsth_pre_clk", int'(gen_if.CLK_EXT), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rsth_clk", int'(gen_if.CLK_EXT), 0);
    chk("rsth_sent", int'(gen_if.Pulses_Sent), 0);
    chk("rsth_busy", int'(gen_if.Gen_Busy), 0);
    gen_if.Test_Start = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_wave("post_rst", 1, 2, 4, 2, 4, 1'b0);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
